uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL declare parameter FIFO_DEPTH, default 16, the TX FIFO depth in words (power of two, at least 2).
REQ-002 The module SHALL declare parameter DIV_WIDTH, default 16, the width of the baud divisor.
REQ-003 The module SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1: system clock; all logic on its rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port tx_enable, input, 1: permits starting new frames.
REQ-007 Port baud_div, input, DIV_WIDTH: bit period minus one, in clk cycles.
REQ-008 Port data_bits, input, 2: 0/1/2/3 = 5/6/7/8 data bits.
REQ-009 Port parity_mode, input, 2: 0 none, 1 even, 2 odd, 3 none.
REQ-010 Port stop_bits, input, 1: 0 = one stop bit, 1 = two stop bits.
REQ-011 Port wr_data, input, 8: byte to queue.
REQ-012 Port wr_valid, input, 1: write request.
REQ-013 Port wr_ready, output, 1: FIFO can accept a byte.
REQ-014 Port tx, output, 1: serial line, idle high.
REQ-015 Port busy, output, 1: a frame is in progress.
REQ-016 Port fifo_count, output, $clog2(FIFO_DEPTH)+1: occupancy.

Function
REQ-017 A write SHALL occur on any cycle where wr_valid and wr_ready are both high.
REQ-018 wr_ready SHALL equal not-full, independent of a same-cycle pop.
REQ-019 The FSM SHALL use states IDLE, START, DATA, PARITY and STOP.
REQ-020 IDLE SHALL go to START when tx_enable is high and the FIFO is non-empty.
- That cycle pops one byte.
- That cycle latches data_bits, parity_mode, stop_bits and baud_div for the whole frame.
REQ-021 Each non-IDLE state bit SHALL last exactly baud_div+1 clk cycles.
- The baud counter clears on frame start and on each bit boundary.
- baud_div=0 gives one-cycle bits.
REQ-022 tx SHALL be registered: 0 in START, data LSB first in DATA, the parity bit in PARITY, 1 in STOP and IDLE.
REQ-023 DATA SHALL send exactly data_bits+5 bits; unused upper bits of the byte are ignored.
REQ-024 The parity bit SHALL be the XOR of the transmitted data bits for even parity, and its inverse for odd parity.
- The PARITY state is skipped when parity is none.
REQ-025 STOP SHALL last one or two bit periods per the latched stop_bits.
- At the end of STOP, the FSM goes to START if the REQ-020 condition holds; otherwise to IDLE.
- Back-to-back frames have no idle gap.
REQ-026 busy SHALL be high in every state except IDLE.
REQ-027 Deasserting tx_enable mid-frame SHALL let the current frame complete; no further frame starts.
REQ-028 fifo_count SHALL update one cycle after a push or pop; a simultaneous push and pop leaves it unchanged.
REQ-029 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-030 On rst, the module SHALL force tx=1, busy=0, fifo_count=0, wr_ready=1, state IDLE, baud counter 0, and empty FIFO pointers, on the next clk edge.
REQ-031 A reset mid-frame SHALL abort the frame, with tx high on the cycle after rst is sampled.
- Queued bytes are discarded.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state enum, the parity_mode encoding constants, and the data_bits encoding.
REQ-033 A synchronous FIFO sub-module uart_fifo SHALL be parametrised by width and depth, and SHALL expose a count output.
REQ-034 The baud counter and FSM SHALL reside in uart_tx.

Verification
REQ-035 Scenario 8N1: baud_div=3, write 0x55.
- tx low for 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, then high for 4 clocks.
- busy is high for exactly 40 clocks.
REQ-036 Scenario 8E1/8O1: baud_div=0, byte 0x07.
- Even parity gives parity bit 1; odd parity gives 0.
- Total frame length is 11 clocks.
REQ-037 Scenario 5N2: data_bits=0, stop_bits=1, baud_div=1, byte 0xFF.
- Five 1 data bits, then stop high for 4 clocks.
- The frame lasts 16 clocks.
REQ-038 Scenario fill with tx_enable=0: write 17 bytes back-to-back.
- fifo_count reaches 16 and wr_ready drops.
- The 17th byte is not accepted.
- Raising tx_enable sends the 16 bytes in order with no idle gaps.
REQ-039 Scenario reset mid-frame: assert rst during the DATA bit 3 of 0xA5.
- Next cycle: tx=1, busy=0, fifo_count=0.
- Any subsequent write starts a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter files.
//   uart_state_e      - transmitter FSM state encoding
//   PARITY_*          - parity_mode field encoding
//   DATA_BITS_*       - data_bits field encoding (value + 5 = data bits)
//   last_bit_index()  - index of the final data bit for a data_bits code
//   parity_of()       - parity bit for a byte under a given frame format
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PARITY_NONE     = 2'd0;
  localparam logic [1:0] PARITY_EVEN     = 2'd1;
  localparam logic [1:0] PARITY_ODD      = 2'd2;
  localparam logic [1:0] PARITY_NONE_ALT = 2'd3;

  localparam logic [1:0] DATA_BITS_5 = 2'd0;
  localparam logic [1:0] DATA_BITS_6 = 2'd1;
  localparam logic [1:0] DATA_BITS_7 = 2'd2;
  localparam logic [1:0] DATA_BITS_8 = 2'd3;

  // 5 data bits -> index 4, ... 8 data bits -> index 7.
  function automatic logic [2:0] last_bit_index(input logic [1:0] db);
    return {1'b0, db} + 3'd4;
  endfunction

  // Only the bits actually sent contribute; odd parity is the inverse.
  function automatic logic parity_of(input logic [7:0] data,
                                     input logic [1:0] db,
                                     input logic [1:0] pm);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - db);
    return (^(data & mask)) ^ (pm == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous show-ahead FIFO.
//   clk, rst      - clock, synchronous active-high reset (empties the FIFO)
//   push/push_data- write strobe and data; ignored while full
//   pop           - consume head entry; ignored while empty
//   pop_data      - current head entry (valid while !empty)
//   full, empty   - occupancy flags
//   count         - number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == DEPTH[AW:0]);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter.
//   clk, rst     - clock, synchronous active-high reset (aborts frame, empties FIFO)
//   tx_enable    - allow new frames to start (a running frame always completes)
//   baud_div     - bit period minus one, in clk cycles
//   data_bits    - 0..3 = 5..8 data bits
//   parity_mode  - 0 none, 1 even, 2 odd, 3 none
//   stop_bits    - 0 one stop bit, 1 two stop bits
//   wr_data/wr_valid/wr_ready - byte write port into the TX FIFO
//   tx           - registered serial output, idle high
//   busy         - high whenever a frame is in progress
//   fifo_count   - TX FIFO occupancy
//
// Write handshake: a byte is taken on every rising edge where wr_valid and
// wr_ready are both high. wr_ready is simply "FIFO not full" and does not
// look at a pop happening in the same cycle. wr_data must be stable while
// wr_valid is high; wr_valid may be held across several accepted writes.
//
// Frame format and divisor are captured when a byte is popped, so the
// configuration inputs may change freely without corrupting a frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_enable,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [1:0]                    data_bits,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop_bits,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  logic [7:0]           fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;

  uart_state_e          state_q;
  logic [DIV_WIDTH-1:0] baud_cnt_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [7:0]           shift_q;
  logic [2:0]           bit_idx_q;
  logic [2:0]           last_bit_q;
  logic                 par_en_q;
  logic                 par_bit_q;
  logic                 stop2_q;
  logic                 stop_idx_q;
  logic                 tx_q;

  logic                 bit_end;
  logic                 stop_done;

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign wr_ready = !fifo_full;
  assign tx       = tx_q;
  assign busy     = (state_q != ST_IDLE);

  assign bit_end   = (baud_cnt_q == div_q);
  // Last stop period just finished: the point where a following frame may
  // begin without any idle gap.
  assign stop_done = (state_q == ST_STOP) && bit_end && (!stop2_q || stop_idx_q);
  assign pop       = tx_enable && !fifo_empty &&
                     ((state_q == ST_IDLE) || stop_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      baud_cnt_q <= '0;
      div_q      <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      last_bit_q <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE || bit_end) baud_cnt_q <= '0;
      else                               baud_cnt_q <= baud_cnt_q + 1'b1;

      case (state_q)
        ST_START: begin
          if (bit_end) begin
            state_q   <= ST_DATA;
            tx_q      <= shift_q[0];
            bit_idx_q <= '0;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx_q == last_bit_q) begin
              if (par_en_q) begin
                state_q <= ST_PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q    <= ST_STOP;
                tx_q       <= 1'b1;
                stop_idx_q <= 1'b0;
              end
            end else begin
              // shift_q[0] is always the bit currently on the line.
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[1];
              shift_q   <= shift_q >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state_q    <= ST_STOP;
            tx_q       <= 1'b1;
            stop_idx_q <= 1'b0;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (stop2_q && !stop_idx_q) stop_idx_q <= 1'b1;
            else if (!pop)              state_q    <= ST_IDLE;
          end
        end
        default: ;
      endcase

      // Frame start (from IDLE or straight out of STOP): latch the popped
      // byte and the whole frame configuration.
      if (pop) begin
        state_q    <= ST_START;
        tx_q       <= 1'b0;
        shift_q    <= fifo_rd_data;
        div_q      <= baud_div;
        last_bit_q <= last_bit_index(data_bits);
        par_en_q   <= (parity_mode == PARITY_EVEN) || (parity_mode == PARITY_ODD);
        par_bit_q  <= parity_of(fifo_rd_data, data_bits, parity_mode);
        stop2_q    <= stop_bits;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// A monitor rebuilds every expected frame from the byte queue and the
// programmed format (start, data LSB first, optional parity, stop bits,
// each held baud_div+1 cycles) and compares the line cycle by cycle.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_enable;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic [1:0]  parity_mode;
  logic        stop_bits;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        tx;
  logic        busy;
  logic [4:0]  fifo_count;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          in_reset = 1'b0;

  logic [7:0]  exp_q[$];    // bytes expected on the line, in order
  int          exp_w_q[$];  // cycle number of the edge that wrote each byte

  uart_tx #(.FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_enable   (tx_enable),
    .baud_div    (baud_div),
    .data_bits   (data_bits),
    .parity_mode (parity_mode),
    .stop_bits   (stop_bits),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .tx          (tx),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks (called at posedge+#1) ----------------
  task automatic set_cfg(input logic [1:0] db, input logic [1:0] pm,
                         input logic sb, input logic [15:0] div);
    data_bits = db; parity_mode = pm; stop_bits = sb; baud_div = div;
  endtask

  task automatic write_byte(input logic [7:0] b);
    bit ok;
    int n;
    n = 0;
    wr_data  = b;
    wr_valid = 1'b1;
    ok = 1'b0;
    while (!ok && n < 2000) begin
      ok = wr_ready;
      @(posedge clk); #1;
      n++;
    end
    wr_valid = 1'b0;
    if (ok) begin
      exp_q.push_back(b);
      exp_w_q.push_back(cyc);
    end else begin
      check_val("write_timeout", 0, 1);
    end
  endtask

  task automatic wait_busy(input string tag, input int budget);
    int n;
    n = 0;
    while (!busy && n < budget) begin @(posedge clk); #1; n++; end
    if (!busy) check_val(tag, 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin @(posedge clk); #1; n++; end
    check_val("drain", (exp_q.size() == 0 && !busy), 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic send_measure(input logic [7:0] b, input int exp_len, input string tag);
    int len;
    write_byte(b);
    wait_busy({tag, "_start"}, 100);
    len = 0;
    while (busy && len < 1000) begin len++; @(posedge clk); #1; end
    check_val(tag, len, exp_len);
    wait_idle(2000);
  endtask

  // ---------------- reference monitor ----------------
  task automatic run_frames();
    bit more;
    more = 1'b1;
    while (more) begin
      logic [7:0] b;
      logic [7:0] sent;
      logic [7:0] dec;
      logic       bits_q[$];
      logic       par;
      logic       en_end;
      bit         avail;
      int         n, per, total, errs;
      b = 8'h00; sent = 8'h00; dec = 8'h00; par = 1'b0;
      en_end = 1'b0; avail = 1'b0; errs = 0;
      if (exp_q.size() == 0) check_val("frame_expected", 0, 1);
      else begin
        b = exp_q.pop_front();
        void'(exp_w_q.pop_front());
      end
      n   = int'(data_bits) + 5;
      per = int'(baud_div) + 1;
      bits_q.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
        bits_q.push_back(b[i]);
        sent[i] = b[i];
        par ^= b[i];
      end
      if (parity_mode == 2'd1) bits_q.push_back(par);
      if (parity_mode == 2'd2) bits_q.push_back(~par);
      bits_q.push_back(1'b1);
      if (stop_bits) bits_q.push_back(1'b1);
      total = bits_q.size() * per;
      for (int k = 0; k < total; k++) begin
        if (k > 0) @(negedge clk);
        if (in_reset) return;
        if (tx !== bits_q[k / per] || busy !== 1'b1) errs++;
        if ((k % per) == per / 2 && k / per >= 1 && k / per <= n) dec[k / per - 1] = tx;
        if (k == total - 1) begin
          en_end = tx_enable;
          avail  = (exp_w_q.size() > 0) && (exp_w_q[0] <= cyc);
        end
      end
      check_val("frame_wave_errs", errs, 0);
      check_val("frame_data", dec, sent);
      @(negedge clk);
      if (in_reset) return;
      if (avail && en_end) begin
        check_val("no_gap", {busy, tx}, 2'b10);
        more = busy;
      end else begin
        check_val("idle_after", {busy, tx}, 2'b01);
        more = 1'b0;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!in_reset && busy) run_frames();
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int model_cnt;
    rst = 1'b1; tx_enable = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
    set_cfg(2'd3, 2'd0, 1'b0, 16'd3);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_tx", tx, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_count", fifo_count, 0);
    check_val("rst_ready", wr_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed frame formats with known lengths.
    tx_enable = 1'b1;
    set_cfg(2'd3, 2'd0, 1'b0, 16'd3); send_measure(8'h55, 40, "len_8n1");
    set_cfg(2'd3, 2'd1, 1'b0, 16'd0); send_measure(8'h07, 11, "len_8e1");
    set_cfg(2'd3, 2'd2, 1'b0, 16'd0); send_measure(8'h07, 11, "len_8o1");
    set_cfg(2'd0, 2'd0, 1'b1, 16'd1); send_measure(8'hFF, 16, "len_5n2");

    // Fill the FIFO with transmission held off; 17th byte must be refused.
    tx_enable = 1'b0;
    set_cfg(2'd3, 2'd1, 1'b0, 16'd1);
    model_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      wr_data  = 8'($urandom);
      wr_valid = 1'b1;
      check_val("fill_ready", wr_ready, (model_cnt < 16));
      @(posedge clk); #1;
      if (model_cnt < 16) begin
        exp_q.push_back(wr_data);
        exp_w_q.push_back(cyc);
        model_cnt++;
      end
      check_val("fill_count", fifo_count, model_cnt);
    end
    wr_valid = 1'b0;
    check_val("full_ready", wr_ready, 0);
    tx_enable = 1'b1;
    wait_idle(5000);
    check_val("drained_count", fifo_count, 0);

    // Dropping tx_enable mid-frame finishes that frame only.
    set_cfg(2'd3, 2'd0, 1'b0, 16'd1);
    write_byte(8'h81); write_byte(8'h42); write_byte(8'h24);
    wait_busy("hold_start", 100);
    tx_enable = 1'b0;
    begin
      int n;
      n = 0;
      while (busy && n < 500) begin @(posedge clk); #1; n++; end
    end
    repeat (3) begin @(posedge clk); #1; end
    check_val("hold_idle", busy, 0);
    check_val("hold_count", fifo_count, 2);
    tx_enable = 1'b1;
    wait_idle(2000);

    // Randomised formats, bytes and write spacing.
    for (int r = 0; r < 10; r++) begin
      int nb;
      set_cfg(2'($urandom), 2'($urandom), 1'($urandom), 16'($urandom_range(0, 3)));
      nb = $urandom_range(1, 6);
      for (int j = 0; j < nb; j++) begin
        repeat ($urandom_range(0, 30)) begin @(posedge clk); #1; end
        write_byte(8'($urandom));
      end
      wait_idle(10000);
    end

    // Reset during data bit 3 of 0xA5, with a second byte queued.
    set_cfg(2'd3, 2'd0, 1'b0, 16'd3);
    write_byte(8'hA5); write_byte(8'h11);
    wait_busy("rst_frame_start", 100);
    repeat (17) begin @(posedge clk); #1; end
    check_val("pre_rst_bit3", tx, 0);
    rst = 1'b1; in_reset = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("midrst_tx", tx, 1);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_count", fifo_count, 0);
    check_val("midrst_ready", wr_ready, 1);
    exp_q.delete(); exp_w_q.delete();
    in_reset = 1'b0;
    write_byte(8'h3C);
    wait_idle(2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
